// File: rtl/conv_psum_accum.sv
// Partial-sum accumulator placed behind the low-bit conv core.
// It sums per-lane signed partials over a configurable number of beats,
// saturating on overflow, and hands each group's final vector downstream.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both high.
// valid never depends on ready. in_ready follows out_ready combinationally while
// a result is held, so a new group can start on the same cycle the old one drains.
module conv_psum_accum #(
  parameter int OC2_LANES = 16,
  parameter int ACC_W     = 32,
  parameter int CNT_W     = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                soft_clear,
  input  logic [CNT_W-1:0]                    cfg_num_beats,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [OC2_LANES-1:0][ACC_W-1:0]     in_partial,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OC2_LANES-1:0][ACC_W-1:0]     out_acc,
  output logic [OC2_LANES-1:0]                out_sat,
  output logic                                busy,
  output logic                                dbg_state
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                             state_q, state_d;
  logic [CNT_W-1:0]                   count_q;
  logic [CNT_W-1:0]                   target_q;
  logic [CNT_W-1:0]                   cfg_eff;
  logic [CNT_W-1:0]                   tgt_now;
  logic [CNT_W:0]                     count_inc;
  logic                               accept;
  logic                               first;
  logic                               last;
  logic [OC2_LANES-1:0][ACC_W-1:0]    acc_q, acc_d;
  logic [OC2_LANES-1:0]               sat_q, sat_d;

  // Returns {overflow_flag, clamped_sum} for a signed ACC_W-bit addition.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      if (sum[ACC_W]) sat_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      else            sat_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_add = {1'b0, sum[ACC_W-1:0]};
    end
  endfunction

  // A programmed beat count of zero behaves like a one-beat group.
  assign cfg_eff   = (cfg_num_beats == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : cfg_num_beats;
  assign first     = (count_q == '0);
  assign tgt_now   = first ? cfg_eff : target_q;
  assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};

  assign in_ready  = !soft_clear && ((state_q == ST_ACC) || out_ready);
  assign accept    = in_valid && in_ready;
  assign last      = accept && (count_inc == {1'b0, tgt_now});

  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (count_q != '0) || (state_q == ST_HOLD);
  assign dbg_state = state_q;

  // Per-lane next accumulator: the first beat loads the partial directly, later beats saturate-add.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    for (int l = 0; l < OC2_LANES; l++) begin
      if (first) begin
        acc_d[l] = in_partial[l];
        sat_d[l] = 1'b0;
      end else begin
        {sat_d[l], acc_d[l]} = sat_add(acc_q[l], in_partial[l]);
        sat_d[l] = sat_d[l] | sat_q[l];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACC;
    else        state_q <= state_d;
  end

  // FSM next state: abort wins, then group completion, then drain of a held result.
  always_comb begin
    state_d = state_q;
    if (soft_clear)                             state_d = ST_ACC;
    else if (last)                              state_d = ST_HOLD;
    else if ((state_q == ST_HOLD) && out_ready) state_d = ST_ACC;
  end

  // Beat counter, working accumulators and the output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      target_q <= '0;
      acc_q    <= '0;
      sat_q    <= '0;
      out_acc  <= '0;
      out_sat  <= '0;
    end else if (soft_clear) begin
      count_q  <= '0;
      out_sat  <= '0;
    end else if (accept) begin
      acc_q <= acc_d;
      sat_q <= sat_d;
      if (first) target_q <= cfg_eff;
      if (last) begin
        count_q <= '0;
        out_acc <= acc_d;
        out_sat <= sat_d;
      end else begin
        count_q <= count_inc[CNT_W-1:0];
      end
    end
  end

endmodule
